// File: rtl/dtree_pkg.sv
// Shared types and node-word layout helpers for the oblique decision-tree walk engine.
package dtree_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    MAC,
    DECIDE,
    DONE
  } dtree_state_t;

  // Node word, LSB first: right ptr, left ptr, threshold, coef[0..N_FEAT-1]
  localparam int RPTR_LSB = 0;

  function automatic int lptr_lsb(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int thr_lsb(input int addr_w);
    return 2 * (addr_w + 1);
  endfunction

  function automatic int coef_lsb(input int addr_w, input int acc_w);
    return 2 * (addr_w + 1) + acc_w;
  endfunction

  function automatic int node_w(input int n_feat, input int coef_w,
                                input int acc_w, input int addr_w);
    return n_feat * coef_w + acc_w + 2 * (addr_w + 1);
  endfunction

  function automatic int leaf_bit(input int addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/dtree_mac.sv
// Sequential signed multiply-accumulate: one product per enabled cycle, wraps modulo 2^ACC_W.
module dtree_mac #(
  parameter int FEAT_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [FEAT_W-1:0] feat,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = FEAT_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_x;

  assign prod   = feat * coef;
  assign prod_x = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_x;
    end
  end

endmodule

// File: rtl/dtree_walk_engine.sv
// Oblique decision-tree walk engine: per node a serial dot product, threshold compare, child follow.
// Optional macro DTREE_DEPTH_OUT_EN adds out_depth (nodes visited, valid with out_valid).
module dtree_walk_engine
  import dtree_pkg::*;
#(
  parameter int N_FEAT    = 4,
  parameter int FEAT_W    = 8,
  parameter int COEF_W    = 8,
  parameter int ACC_W     = FEAT_W + COEF_W + $clog2(N_FEAT) + 1,
  parameter int ADDR_W    = 10,
  parameter int CLASS_W   = 8,
  parameter int ROOT_ADDR = 0,
  parameter int MAX_DEPTH = 32,
  localparam int NODE_W   = node_w(N_FEAT, COEF_W, ACC_W, ADDR_W),
  localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_FEAT*FEAT_W-1:0]   in_feat,
  output logic                       mem_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [NODE_W-1:0]          mem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLASS_W-1:0]         out_class,
  output logic                       out_err
`ifdef DTREE_DEPTH_OUT_EN
  , output logic [DEPTH_W-1:0]       out_depth
`endif
);

  localparam int LPTR_LSB = lptr_lsb(ADDR_W);
  localparam int THR_LSB  = thr_lsb(ADDR_W);
  localparam int COEF_LSB = coef_lsb(ADDR_W, ACC_W);
  localparam int LEAF     = leaf_bit(ADDR_W);
  localparam int KW       = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

  dtree_state_t              state;
  logic [N_FEAT*FEAT_W-1:0]  feat_r;
  logic [NODE_W-1:0]         node_r;
  logic [KW-1:0]             k;
  logic [DEPTH_W-1:0]        depth;
  logic signed [FEAT_W-1:0]  feat_sel;
  logic signed [COEF_W-1:0]  coef_sel;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   thr;
  logic [ADDR_W:0]           lptr;
  logic [ADDR_W:0]           rptr;
  logic [ADDR_W:0]           ptr;

  always_comb begin
    feat_sel = '0;
    coef_sel = '0;
    for (int unsigned i = 0; i < N_FEAT; i++) begin
      if (k == KW'(i)) begin
        feat_sel = feat_r[i*FEAT_W +: FEAT_W];
        coef_sel = node_r[COEF_LSB + i*COEF_W +: COEF_W];
      end
    end
  end

  assign thr  = node_r[THR_LSB +: ACC_W];
  assign lptr = node_r[LPTR_LSB +: ADDR_W+1];
  assign rptr = node_r[RPTR_LSB +: ADDR_W+1];
  // Ties go right: only a strictly smaller dot product takes the left child.
  assign ptr  = (acc < thr) ? lptr : rptr;

  dtree_mac #(
    .FEAT_W(FEAT_W),
    .COEF_W(COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == LOAD),
    .en   (state == MAC),
    .feat (feat_sel),
    .coef (coef_sel),
    .acc  (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_class <= '0;
      out_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      depth     <= '0;
      k         <= '0;
      feat_r    <= '0;
      node_r    <= '0;
`ifdef DTREE_DEPTH_OUT_EN
      out_depth <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            feat_r   <= in_feat;
            mem_addr <= ADDR_W'(ROOT_ADDR);
            mem_en   <= 1'b1;
            depth    <= '0;
            in_ready <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          mem_en <= 1'b0;
          depth  <= depth + 1'b1;
          state  <= LOAD;
        end
        LOAD: begin
          node_r <= mem_rdata;
          k      <= '0;
          state  <= MAC;
        end
        MAC: begin
          if (k == KW'(N_FEAT - 1)) begin
            state <= DECIDE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DECIDE: begin
          if (ptr[LEAF]) begin
            out_class <= ptr[CLASS_W-1:0];
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef DTREE_DEPTH_OUT_EN
            out_depth <= depth;
`endif
          end else if (depth == DEPTH_W'(MAX_DEPTH)) begin
            out_class <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef DTREE_DEPTH_OUT_EN
            out_depth <= depth;
`endif
          end else begin
            mem_addr <= ptr[ADDR_W-1:0];
            mem_en   <= 1'b1;
            state    <= FETCH;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dtree_walk_engine.md
Name: dtree_walk_engine

Overview:
- Parametrised oblique decision-tree inference engine; successor to the single-tree, fixed-width traversal block.
- Accepts one feature vector and walks a tree held in external node memory.
- At each node: computes the signed dot product of features and node coefficients, compares it with the node threshold, and follows the left or right child pointer until a leaf is reached.
- Returns the class ID through a valid/ready result port; sits between the feature front-end and the classifier result FIFO.

Parameters:
- N_FEAT, 4, features per vector = coefficients per node (>=1)
- FEAT_W, 8, signed feature width
- COEF_W, 8, signed coefficient width
- ACC_W, FEAT_W+COEF_W+$clog2(N_FEAT)+1, signed accumulator and threshold width
- ADDR_W, 10, node memory address width
- CLASS_W, 8, class ID width (<= ADDR_W)
- ROOT_ADDR, 0, node address of the tree root
- MAX_DEPTH, 32, node visits allowed before abort

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  feature vector valid
- in_ready  out  1  engine idle, can accept a vector
- in_feat  in  N_FEAT*FEAT_W  features, feat[k] at bits [k*FEAT_W +: FEAT_W]
- mem_en  out  1  node memory read strobe
- mem_addr  out  ADDR_W  node address
- mem_rdata  in  NODE_W  node word, valid the cycle after mem_en; NODE_W = N_FEAT*COEF_W + ACC_W + 2*(ADDR_W+1)
- out_valid  out  1  result valid
- out_ready  in  1  result accepted
- out_class  out  CLASS_W  class ID of the reached leaf
- out_err  out  1  depth limit hit, no leaf reached

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; in_ready=1 after release; out_valid=0; out_class=0; out_err=0; mem_en=0; mem_addr=0; depth counter=0.
- Node word layout, LSB first:
  - right pointer [ADDR_W:0]
  - left pointer [ADDR_W:0]
  - threshold (ACC_W, signed)
  - coef[0]..coef[N_FEAT-1] (signed)
- Pointer format: bit ADDR_W set means leaf, and bits [CLASS_W-1:0] hold the class ID; bit ADDR_W clear means bits [ADDR_W-1:0] hold the next node address.
- FSM states: IDLE, FETCH, LOAD, MAC, DECIDE, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_feat, set addr=ROOT_ADDR, depth=0, go to FETCH.
  - FETCH: mem_en=1 for exactly one cycle, mem_addr=addr, depth+=1, go to LOAD.
  - LOAD: register mem_rdata into the node register, clear acc, go to MAC.
  - MAC: one product per cycle, acc += sext(feat[k])*sext(coef[k]), k=0..N_FEAT-1; N_FEAT cycles, then go to DECIDE.
  - DECIDE: acc < threshold (signed) selects left, else right (equality goes right).
    - Leaf pointer: out_class = class ID, out_err=0, go to DONE.
    - Non-leaf pointer with depth==MAX_DEPTH: out_err=1, out_class=0, go to DONE.
    - Otherwise: addr = pointer, go to FETCH.
  - DONE: out_valid=1. out_class and out_err are held stable until out_ready; on the handshake go to IDLE. out_valid drops the following cycle.
- Latency per node: N_FEAT+3 cycles. Accepting the vector to out_valid: D*(N_FEAT+3)+1 cycles for D nodes visited.
- Accumulator wraps modulo 2^ACC_W. The default ACC_W makes overflow impossible.
- in_ready=0 in every state except IDLE. in_valid in non-IDLE states is ignored; a new vector is never latched in DONE.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-traversal aborts immediately; no partial result is emitted.
- mem_en is never asserted outside FETCH.

Optional Feature:
- Macro: DTREE_DEPTH_OUT_EN.
- Defined: adds output port out_depth ($clog2(MAX_DEPTH+1) bits) holding the number of nodes visited. It is valid and stable with out_valid and reset to 0.
- Undefined: the port is absent and the depth counter is used only for the MAX_DEPTH guard.

Decomposition:
- Package dtree_pkg:
  - state enum dtree_state_t
  - localparams for node-word field offsets (RPTR_LSB, LPTR_LSB, THR_LSB, COEF_LSB) and NODE_W
  - LEAF_BIT position function
- Sub-module dtree_mac: sequential signed multiply-accumulate with clr/en inputs and acc output, parametrised on FEAT_W, COEF_W, ACC_W.

Test Plan:
- Reset: hold rst_n=0 mid-MAC, release -> in_ready=1, out_valid=0, mem_en=0, out_class=0 next cycle.
- Single node, N_FEAT=2: feat=(1,2), coef=(2,3), thr=10, left=leaf class 5, right=leaf class 7 -> acc=8 -> out_class=5, out_err=0, out_valid 6 cycles after handshake.
- Equality: same node with thr=8 -> out_class=7 (right taken).
- Two-level: node0 right->node3, node3 left->leaf class 9 -> mem_addr sequence 0 then 3, out_class=9, latency 11 cycles.
- Depth guard, MAX_DEPTH=4: node0 both pointers -> node0 -> exactly 4 mem_en pulses, out_err=1, out_class=0.
- Backpressure: out_ready=0 for 10 cycles -> out_valid and out_class stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
